// File: rtl/datacache_pkg.sv
// datacache_pkg
//   Shared types and constants for the L1 data cache sequencing logic.
//   - dc_state_e     : controller FSM states (IDLE, CHECK, WB, FILL)
//   - WCS_*          : W_CACHE_STATUS datapath write-mode encodings
//   - sat_inc()      : 32-bit saturating increment used by the perf counters
//   Optional feature macro used elsewhere: DCACHE_PERF_CNT_EN
package datacache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_WB    = 2'd2,
    ST_FILL  = 2'd3
  } dc_state_e;

  // W_CACHE_STATUS encodings seen by datacache_datapath
  localparam logic [2:0] WCS_IDLE    = 3'b000;
  localparam logic [2:0] WCS_CPU_WR  = 3'b100;
  localparam logic [2:0] WCS_WB      = 3'b001;
  localparam logic [2:0] WCS_FILL_RD = 3'b011;
  localparam logic [2:0] WCS_FILL_WR = 3'b111;

  // Increment by one unless already at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
    if (en && (value != 32'hFFFF_FFFF)) begin
      return value + 32'd1;
    end
    return value;
  endfunction

endpackage

// File: rtl/datacache_perf_cnt.sv
// datacache_perf_cnt
//   Three 32-bit saturating event counters for the data cache controller.
//   Only instantiated when DCACHE_PERF_CNT_EN is defined.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset (counters -> 0)
//   hit_inc/miss_inc/wb_inc: one-cycle event strobes
//   hit_count/miss_count/wb_count : counter values
module datacache_perf_cnt
  import datacache_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hit_inc,
  input  logic        miss_inc,
  input  logic        wb_inc,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [31:0] wb_count
);

  logic [31:0] hit_q,  hit_d;
  logic [31:0] miss_q, miss_d;
  logic [31:0] wb_q,   wb_d;

  always_comb begin
    hit_d  = sat_inc(hit_q,  hit_inc);
    miss_d = sat_inc(miss_q, miss_inc);
    wb_d   = sat_inc(wb_q,   wb_inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
      wb_q   <= '0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
      wb_q   <= wb_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign wb_count   = wb_q;

endmodule

// File: rtl/datacache_control.sv
// datacache_control
//   Sequencing FSM for the 2-way, 8-set, 256-bit-line L1 data cache.
//   Looks up CPU requests on the datapath hit flags, updates LRU/dirty/
//   valid/tag state, and sequences victim write-back and line fill over
//   the physical-memory handshake.
// Handshakes:
//   CPU side: mem_read/mem_write are held by the CPU until the one-cycle
//   mem_resp pulse; a request seen in IDLE is answered no earlier than the
//   following cycle. Memory side: pmem_read/pmem_write stay high until the
//   one-cycle pmem_resp pulse, which is ignored outside WB/FILL.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   mem_read, mem_write, mem_resp   : CPU request / completion
//   HIT, way_hit, lru_data,
//   valid_out, dirty_out            : datapath lookup state
//   pmem_read, pmem_write, pmem_resp: memory request / completion
//   LD_DIRTY_in, dirty_in_value,
//   LD_LRU_in, lru_in_value,
//   LD_VALID, valid_in, LD_TAG      : per-way datapath load strobes
//   W_CACHE_STATUS                  : datapath write mode (WCS_*)
//   hit_count, miss_count, wb_count : only with DCACHE_PERF_CNT_EN defined
// Outputs are decoded from the registered state and the current inputs so
// a hit completes in the CHECK cycle itself; reset forces IDLE, where
// every output is 0.
module datacache_control
  import datacache_pkg::*;
#(
  parameter int unsigned NUM_WAYS = 2
)
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_read,
  input  logic                mem_write,
  output logic                mem_resp,
  input  logic                HIT,
  input  logic                way_hit,
  input  logic                lru_data,
  input  logic [NUM_WAYS-1:0] valid_out,
  input  logic [NUM_WAYS-1:0] dirty_out,
  output logic                pmem_read,
  output logic                pmem_write,
  input  logic                pmem_resp,
  output logic [NUM_WAYS-1:0] LD_DIRTY_in,
  output logic                dirty_in_value,
  output logic                LD_LRU_in,
  output logic                lru_in_value,
  output logic [NUM_WAYS-1:0] LD_VALID,
  output logic                valid_in,
  output logic [NUM_WAYS-1:0] LD_TAG,
  output logic [2:0]          W_CACHE_STATUS
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count,
  output logic [31:0]         wb_count
`endif
);

  dc_state_e state_q, state_d;
  logic      req;
  logic      victim_dirty;

  // Simultaneous read and write is handled as a write (mem_write decides).
  assign req          = mem_read | mem_write;
  // The LRU way is the victim; only a valid and dirty victim needs write-back.
  assign victim_dirty = valid_out[lru_data] & dirty_out[lru_data];

  always_comb begin
    state_d        = state_q;
    mem_resp       = 1'b0;
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    LD_DIRTY_in    = '0;
    dirty_in_value = 1'b0;
    LD_LRU_in      = 1'b0;
    lru_in_value   = 1'b0;
    LD_VALID       = '0;
    valid_in       = 1'b0;
    LD_TAG         = '0;
    W_CACHE_STATUS = WCS_IDLE;

    unique case (state_q)
      ST_IDLE: begin
        if (req) state_d = ST_CHECK;
      end

      ST_CHECK: begin
        if (!req) begin
          // Request withdrawn: drop back without a response.
          state_d = ST_IDLE;
        end else if (HIT) begin
          mem_resp     = 1'b1;
          LD_LRU_in    = 1'b1;
          lru_in_value = ~way_hit;  // other way becomes least recently used
          if (mem_write) begin
            W_CACHE_STATUS       = WCS_CPU_WR;
            LD_DIRTY_in[way_hit] = 1'b1;
            dirty_in_value       = 1'b1;
          end
          state_d = ST_IDLE;
        end else if (victim_dirty) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FILL;
        end
      end

      ST_WB: begin
        W_CACHE_STATUS = WCS_WB;
        pmem_write     = 1'b1;
        if (pmem_resp) state_d = ST_FILL;
      end

      ST_FILL: begin
        W_CACHE_STATUS = WCS_FILL_RD;
        pmem_read      = 1'b1;
        if (pmem_resp) begin
          // Install the fetched line in the victim way as clean and valid,
          // then re-run the lookup, which now hits.
          W_CACHE_STATUS        = WCS_FILL_WR;
          LD_TAG[lru_data]      = 1'b1;
          LD_VALID[lru_data]    = 1'b1;
          valid_in              = 1'b1;
          LD_DIRTY_in[lru_data] = 1'b1;
          dirty_in_value        = 1'b0;
          state_d               = ST_CHECK;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

`ifdef DCACHE_PERF_CNT_EN
  // refill_q marks the CHECK that follows a fill so its hit is not counted
  // as a fresh CPU hit.
  logic refill_q, refill_d;
  logic hit_inc, miss_inc, wb_inc;

  always_comb begin
    refill_d = refill_q;
    if ((state_q == ST_FILL) && pmem_resp) refill_d = 1'b1;
    else if (state_q == ST_CHECK)          refill_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) refill_q <= 1'b0;
    else        refill_q <= refill_d;
  end

  assign hit_inc  = (state_q == ST_CHECK) && req && HIT && !refill_q;
  assign miss_inc = (state_q == ST_CHECK) && req && !HIT;
  assign wb_inc   = (state_q == ST_WB) && pmem_resp;

  datacache_perf_cnt u_perf_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .hit_inc    (hit_inc),
    .miss_inc   (miss_inc),
    .wb_inc     (wb_inc),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .wb_count   (wb_count)
  );
`endif

endmodule

// File: tb/tb_datacache_control.sv
// tb_datacache_control
//   Directed bench for datacache_control. The bench plays the datapath
//   (HIT/way_hit/lru_data/valid/dirty) and memory (pmem_resp). Inputs change
//   2 time units after a rising edge and outputs are sampled 1 unit later.
//   Perf counter checks are compiled in only with DCACHE_PERF_CNT_EN.
module tb_datacache_control;

  logic       clk;
  logic       rst_n;
  logic       mem_read, mem_write, mem_resp;
  logic       HIT, way_hit, lru_data;
  logic [1:0] valid_out, dirty_out;
  logic       pmem_read, pmem_write, pmem_resp;
  logic [1:0] LD_DIRTY_in;
  logic       dirty_in_value, LD_LRU_in, lru_in_value;
  logic [1:0] LD_VALID;
  logic       valid_in;
  logic [1:0] LD_TAG;
  logic [2:0] W_CACHE_STATUS;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  int n_cmp;
  int n_fail;

  logic [15:0] out_vec;
  logic [15:0] exp;
  localparam logic [15:0] ZERO = 16'h0000;

  assign out_vec = {mem_resp, pmem_read, pmem_write, LD_DIRTY_in, dirty_in_value,
                    LD_LRU_in, lru_in_value, LD_VALID, valid_in, LD_TAG, W_CACHE_STATUS};

  datacache_control #(.NUM_WAYS(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_resp       (mem_resp),
    .HIT            (HIT),
    .way_hit        (way_hit),
    .lru_data       (lru_data),
    .valid_out      (valid_out),
    .dirty_out      (dirty_out),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_resp      (pmem_resp),
    .LD_DIRTY_in    (LD_DIRTY_in),
    .dirty_in_value (dirty_in_value),
    .LD_LRU_in      (LD_LRU_in),
    .lru_in_value   (lru_in_value),
    .LD_VALID       (LD_VALID),
    .valid_in       (valid_in),
    .LD_TAG         (LD_TAG),
    .W_CACHE_STATUS (W_CACHE_STATUS)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count),
    .wb_count       (wb_count)
`endif
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected run to finish");
    $fatal(1, "watchdog");
  end

  // Expected output vector, same field order as out_vec.
  function automatic logic [15:0] pack(input logic resp, input logic prd, input logic pwr,
                                       input logic [1:0] ldd, input logic dv, input logic ldl,
                                       input logic lv, input logic [1:0] ldv, input logic vi,
                                       input logic [1:0] ldt, input logic [2:0] wcs);
    return {resp, prd, pwr, ldd, dv, ldl, lv, ldv, vi, ldt, wcs};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    HIT       = 1'b0;
    way_hit   = 1'b0;
    lru_data  = 1'b0;
    valid_out = 2'b00;
    dirty_out = 2'b00;
    pmem_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #3;
    n_cmp++;
    if (out_vec !== ZERO) begin n_fail++; $display("FAIL reset_outputs: got %b expected %b", out_vec, ZERO); end
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    n_cmp++;
    if (out_vec !== ZERO) begin n_fail++; $display("FAIL reset_idle: got %b expected %b", out_vec, ZERO); end
  endtask

  task automatic test_read_hit();
    mem_read = 1'b1; HIT = 1'b1; way_hit = 1'b0; lru_data = 1'b1; valid_out = 2'b01;
    #1;
    n_cmp++;
    if (out_vec !== ZERO) begin n_fail++; $display("FAIL rh_idle: got %b expected %b", out_vec, ZERO); end
    tick(); #1;
    exp = pack(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 3'b000);
    n_cmp++;
    if (out_vec !== exp) begin n_fail++; $display("FAIL rh_resp: got %b expected %b", out_vec, exp); end
    tick();
    clear_inputs();
    #1;
    n_cmp++;
    if (out_vec !== ZERO) begin n_fail++; $display("FAIL rh_back_idle: got %b expected %b", out_vec, ZERO); end
  endtask

  task automatic test_write_hit();
    mem_write = 1'b1; HIT = 1'b1; way_hit = 1'b1; lru_data = 1'b0; valid_out = 2'b11;
    tick(); #1;
    exp = pack(1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 3'b100);
    n_cmp++;
    if (out_vec !== exp) begin n_fail++; $display("FAIL wh_resp: got %b expected %b", out_vec, exp); end
    tick();
    clear_inputs();
  endtask

  task automatic test_read_write_both();
    mem_read = 1'b1; mem_write = 1'b1; HIT = 1'b1; way_hit = 1'b0; valid_out = 2'b01;
    tick(); #1;
    exp = pack(1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 3'b100);
    n_cmp++;
    if (out_vec !== exp) begin n_fail++; $display("FAIL rw_as_write: got %b expected %b", out_vec, exp); end
    tick();
    clear_inputs();
  endtask

  // Victim way 1 is valid but clean; way 0 dirty must not matter.
  task automatic test_clean_miss();
    mem_read = 1'b1; HIT = 1'b0; lru_data = 1'b1; valid_out = 2'b10; dirty_out = 2'b01;
    tick(); #1;
    n_cmp++;
    if (out_vec !== ZERO) begin n_fail++; $display("FAIL cm_check: got %b expected %b", out_vec, ZERO); end
    exp = pack(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b011);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      n_cmp++;
      if (out_vec !== exp) begin n_fail++; $display("FAIL cm_fill_%0d: got %b expected %b", i, out_vec, exp); end
    end
    tick();
    pmem_resp = 1'b1;
    #1;
    exp = pack(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 3'b111);
    n_cmp++;
    if (out_vec !== exp) begin n_fail++; $display("FAIL cm_install: got %b expected %b", out_vec, exp); end
    tick();
    pmem_resp = 1'b0; HIT = 1'b1; way_hit = 1'b1; valid_out = 2'b11;
    #1;
    exp = pack(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000);
    n_cmp++;
    if (out_vec !== exp) begin n_fail++; $display("FAIL cm_resp: got %b expected %b", out_vec, exp); end
    tick();
    clear_inputs();
  endtask

  // Victim way 0 valid and dirty: WB (3 cycles) then FILL (2 cycles).
  task automatic test_dirty_miss();
    mem_write = 1'b1; HIT = 1'b0; lru_data = 1'b0; valid_out = 2'b11; dirty_out = 2'b01;
    tick(); #1;
    n_cmp++;
    if (out_vec !== ZERO) begin n_fail++; $display("FAIL dm_check: got %b expected %b", out_vec, ZERO); end
    exp = pack(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b001);
    for (int i = 0; i < 3; i++) begin
      tick();
      pmem_resp = (i == 2);
      #1;
      n_cmp++;
      if (out_vec !== exp) begin n_fail++; $display("FAIL dm_wb_%0d: got %b expected %b", i, out_vec, exp); end
    end
    tick();
    pmem_resp = 1'b0;
    #1;
    exp = pack(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b011);
    n_cmp++;
    if (out_vec !== exp) begin n_fail++; $display("FAIL dm_fill_after_wb: got %b expected %b", out_vec, exp); end
    tick();
    pmem_resp = 1'b1;
    #1;
    exp = pack(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 2'b01, 3'b111);
    n_cmp++;
    if (out_vec !== exp) begin n_fail++; $display("FAIL dm_install: got %b expected %b", out_vec, exp); end
    tick();
    pmem_resp = 1'b0; HIT = 1'b1; way_hit = 1'b0; dirty_out = 2'b00;
    #1;
    exp = pack(1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 3'b100);
    n_cmp++;
    if (out_vec !== exp) begin n_fail++; $display("FAIL dm_cpu_write: got %b expected %b", out_vec, exp); end
    tick();
    clear_inputs();
  endtask

  // Stray pmem_resp in IDLE, then a request withdrawn while in CHECK.
  task automatic test_stray_and_drop();
    pmem_resp = 1'b1;
    tick(); tick();
    pmem_resp = 1'b0;
    #1;
    n_cmp++;
    if (out_vec !== ZERO) begin n_fail++; $display("FAIL stray_resp_idle: got %b expected %b", out_vec, ZERO); end
    mem_read = 1'b1; HIT = 1'b0; lru_data = 1'b0; valid_out = 2'b00;
    tick();
    mem_read = 1'b0;
    #1;
    n_cmp++;
    if (out_vec !== ZERO) begin n_fail++; $display("FAIL drop_in_check: got %b expected %b", out_vec, ZERO); end
    tick(); #1;
    n_cmp++;
    if (out_vec !== ZERO) begin n_fail++; $display("FAIL drop_to_idle: got %b expected %b", out_vec, ZERO); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_fill();
    mem_read = 1'b1; HIT = 1'b0; lru_data = 1'b1; valid_out = 2'b00;
    tick(); tick(); #1;
    exp = pack(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b011);
    n_cmp++;
    if (out_vec !== exp) begin n_fail++; $display("FAIL rst_pre_fill: got %b expected %b", out_vec, exp); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_vec !== ZERO) begin n_fail++; $display("FAIL rst_async_zero: got %b expected %b", out_vec, ZERO); end
    clear_inputs();
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    rst_n = 1'b1;
    mem_read = 1'b1; HIT = 1'b1; way_hit = 1'b1; valid_out = 2'b10;
    #1;
    n_cmp++;
    if (out_vec !== ZERO) begin n_fail++; $display("FAIL rst_release_idle: got %b expected %b", out_vec, ZERO); end
    tick(); #1;
    exp = pack(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000);
    n_cmp++;
    if (out_vec !== exp) begin n_fail++; $display("FAIL rst_then_read: got %b expected %b", out_vec, exp); end
    tick();
    clear_inputs();
  endtask

`ifdef DCACHE_PERF_CNT_EN
  task automatic test_perf_counters();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({hit_count, miss_count, wb_count} !== 96'd0) begin
      n_fail++; $display("FAIL perf_reset: got %0d/%0d/%0d expected 0/0/0", hit_count, miss_count, wb_count);
    end
    tick();
    rst_n = 1'b1;
    test_read_hit();
    test_write_hit();
    test_dirty_miss();
    n_cmp++;
    if (hit_count !== 32'd2) begin n_fail++; $display("FAIL perf_hit: got %0d expected 2", hit_count); end
    n_cmp++;
    if (miss_count !== 32'd1) begin n_fail++; $display("FAIL perf_miss: got %0d expected 1", miss_count); end
    n_cmp++;
    if (wb_count !== 32'd1) begin n_fail++; $display("FAIL perf_wb: got %0d expected 1", wb_count); end
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_read_hit();
    test_write_hit();
    test_read_write_both();
    test_clean_miss();
    test_dirty_miss();
    test_stray_and_drop();
    test_reset_mid_fill();
`ifdef DCACHE_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/datacache_control.md
# datacache_control

Sequencing FSM for the 2-way, 8-set, 256-bit-line L1 data cache datapath. Accepts CPU read/write requests, checks hit/miss on the datapath's hit flags, and updates LRU, dirty, valid and tag state. Sequences victim write-back and line fill over the 256-bit physical-memory handshake and selects the datapath write mode via `W_CACHE_STATUS`. Sits between the CPU memory port, `datacache_datapath` and the cacheline adaptor / arbiter.

## Interface
Parameters:
- `NUM_WAYS`, 2, associativity; only 2 supported.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_read`  in  1  CPU read request; held until `mem_resp`.
- `mem_write`  in  1  CPU write request; held until `mem_resp`.
- `mem_resp`  out  1  one-cycle CPU completion pulse.
- `HIT`  in  1  datapath: tag match on a valid way.
- `way_hit`  in  1  datapath: matching way.
- `lru_data`  in  1  datapath: victim way for the current set.
- `valid_out`  in  2  datapath: per-way valid bits.
- `dirty_out`  in  2  datapath: per-way dirty bits.
- `pmem_read`  out  1  line-fill request to memory.
- `pmem_write`  out  1  write-back request to memory.
- `pmem_resp`  in  1  memory completion pulse.
- `LD_DIRTY_in`  out  2  per-way dirty load.
- `dirty_in_value`  out  1  dirty value to load.
- `LD_LRU_in`  out  1  LRU load.
- `lru_in_value`  out  1  LRU value to load.
- `LD_VALID`  out  2  per-way valid load.
- `valid_in`  out  1  valid value to load.
- `LD_TAG`  out  2  per-way tag load.
- `W_CACHE_STATUS`  out  3  datapath mode: 000 idle, 100 CPU write, 001 write-back, 011 fill read, 111 fill install.

## Operation
- States: IDLE, CHECK, WB, FILL.
- IDLE: all outputs 0. On `mem_read|mem_write`, go to CHECK.
- CHECK, `HIT`=1:
  - Pulse `mem_resp`.
  - Set `LD_LRU_in`=1 and `lru_in_value`=~`way_hit`.
  - On write, also drive `W_CACHE_STATUS`=100, `LD_DIRTY_in[way_hit]`=1 and `dirty_in_value`=1.
  - Go to IDLE.
- CHECK, `HIT`=0: if `valid_out[v]&dirty_out[v]` (v=`lru_data`), go to WB; otherwise go to FILL.
- CHECK with no request (request dropped): return to IDLE with no response.
- WB: drive `W_CACHE_STATUS`=001 and `pmem_write`=1 until `pmem_resp`, then go to FILL.
- FILL: drive `W_CACHE_STATUS`=011 and `pmem_read`=1. On the `pmem_resp` cycle:
  - Drive `W_CACHE_STATUS`=111.
  - Set `LD_TAG[v]`=`LD_VALID[v]`=1, `valid_in`=1, `LD_DIRTY[v]`=1, `dirty_in_value`=0.
  - Go to CHECK, which re-looks-up, hits, and completes.
- Simultaneous `mem_read` and `mem_write`: treated as a write.
- `pmem_resp` outside WB/FILL is ignored.
- `LD_*` outputs for the non-selected way are always 0; load strobes are combinational, one cycle.

## Timing
- Reset (async, `rst_n`=0): state goes to IDLE and all outputs are 0 immediately. An in-flight pmem transaction is abandoned.
- Read or write hit: request seen at edge 0, `mem_resp` in cycle 1. Latency 2 cycles, including IDLE.
- Clean miss: CHECK (1) + FILL (N cycles until `pmem_resp`) + CHECK (1). `mem_resp` follows 1 cycle after `pmem_resp`.
- Dirty miss: CHECK + WB (M) + FILL (N) + CHECK.
- Back-to-back requests: the earliest re-accept is the cycle after `mem_resp`, since IDLE is always visited.

## Configuration
- `DCACHE_PERF_CNT_EN` defined: adds outputs `hit_count`, `miss_count` and `wb_count`, each 32 bits.
  - Increment on: CHECK hit with an original request (fill re-check excluded), CHECK→WB/FILL, and WB completion respectively.
  - Counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: the counter ports and logic are absent. FSM behaviour is identical in both cases.

## Structure
- `datacache_pkg`:
  - state enum `dc_state_e`;
  - `W_CACHE_STATUS` encodings `WCS_IDLE`, `WCS_CPU_WR`, `WCS_WB`, `WCS_FILL_RD`, `WCS_FILL_WR`.
- Sub-module `datacache_perf_cnt` (three saturating counters), instantiated only under the macro.

## Test plan
- Read hit: preload set 3, way 0; issue `mem_read` → `mem_resp` in cycle 1, `LD_LRU_in`=1, `lru_in_value`=1, no pmem activity.
- Write hit on way 1 → `W_CACHE_STATUS`=100, `LD_DIRTY_in`=2'b10, `dirty_in_value`=1, `lru_in_value`=0, `mem_resp` in cycle 1.
- Clean read miss, memory latency 5 → `pmem_read` high 5 cycles. In the `pmem_resp` cycle: `W_CACHE_STATUS`=111, `LD_TAG`/`LD_VALID` on way `lru_data`. Then `mem_resp` 1 cycle later.
- Dirty write miss → `pmem_write` with `W_CACHE_STATUS`=001 until `pmem_resp`, then fill, then CPU write with dirty=1. Check ordering: WB before FILL.
- `rst_n` low mid-FILL → all outputs 0 asynchronously; after release, state is IDLE and a new read is served correctly.
- With `DCACHE_PERF_CNT_EN`: 2 hits + 1 dirty miss → `hit_count`=2, `miss_count`=1, `wb_count`=1.
